// File: rtl/spi_reg_bank.sv
// spi_reg_bank: byte-level command decoder and register file behind an SPI
// slave shifter. The first byte of a frame is a command: bit 7 is the write
// flag and bits [6:0] are the start address. The bytes after it are either
// write data or dummy bytes, and the shifter returns read data in place of
// each dummy byte.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   ss         raw slave-select (active low, asynchronous to clk)
//   rxdata     received byte, valid while rxready is high
//   rxready    one-cycle pulse for each completed byte
//   txready    one-cycle pulse when the shifter captures txdata
//   txdata     next byte for the shifter to transmit
//   ro_data    read-only status byte, readable at address 7'h7F
//   regs_out   flattened register contents; reg i sits at [8i+7:8i]
//   wr_strobe  one-cycle pulse for each register write
//   wr_addr    address of the last write
//
// Build option SPI_REG_BANK_AUTOINC_EN:
//   defined   - the pointer advances after every data byte (burst access)
//   undefined - the pointer stays at the start address for the whole frame
module spi_reg_bank #(
  parameter int         NREGS     = 8,
  parameter logic [7:0] ID_BYTE   = 8'hA5,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ss,
  input  logic [7:0]         rxdata,
  input  logic               rxready,
  input  logic               txready,
  output logic [7:0]         txdata,
  input  logic [7:0]         ro_data,
  output logic [8*NREGS-1:0] regs_out,
  output logic               wr_strobe,
  output logic [6:0]         wr_addr
);

`ifdef SPI_REG_BANK_AUTOINC_EN
  localparam logic [6:0] PTR_INC = 7'd1;
`else
  localparam logic [6:0] PTR_INC = 7'd0;
`endif
  localparam logic [7:0] NREGS_W = 8'(NREGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  state_e     state_q;
  logic [6:0] ptr_q;
  logic [7:0] txdata_q;
  logic [7:0] regs_q [NREGS];
  logic       wr_strobe_q;
  logic [6:0] wr_addr_q;
  logic [1:0] ss_sync_q;
  logic       tx_pending_q;
  logic       selected;

  assign selected = ~ss_sync_q[1];

  // Read mux: register file, then the status byte at the top address, else 0.
  function automatic logic [7:0] rd(input logic [6:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NREGS; i++) begin
      if (a == 7'(i)) r = regs_q[i];
    end
    if (a == 7'h7F) r = ro_data;
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ptr_q        <= 7'd0;
      txdata_q     <= ID_BYTE;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= 7'd0;
      ss_sync_q    <= 2'b11;
      tx_pending_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      ss_sync_q   <= {ss_sync_q[0], ss};
      wr_strobe_q <= 1'b0;
      if (txready) tx_pending_q <= 1'b0;

      if (rxready) begin
        case (state_q)
          IDLE: begin
            if (rxdata[7]) begin
              state_q <= WRITE;
              ptr_q   <= rxdata[6:0];
            end else begin
              state_q      <= READ;
              txdata_q     <= rd(rxdata[6:0]);
              tx_pending_q <= 1'b1;
              ptr_q        <= rxdata[6:0] + PTR_INC;
            end
          end
          WRITE: begin
            if ({1'b0, ptr_q} < NREGS_W) begin
              for (int i = 0; i < NREGS; i++) begin
                if (ptr_q == 7'(i)) regs_q[i] <= rxdata;
              end
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= ptr_q;
            end
            ptr_q <= ptr_q + PTR_INC;
          end
          READ: begin
            txdata_q     <= rd(ptr_q);
            tx_pending_q <= 1'b1;
            ptr_q        <= ptr_q + PTR_INC;
          end
          default: state_q <= IDLE;
        endcase
      end

      // Deselect overrides the byte handling above, so a byte arriving in the
      // same cycle is still applied before the frame is closed.
      if (!selected) begin
        state_q  <= IDLE;
        txdata_q <= ID_BYTE;
        ptr_q    <= 7'd0;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs_out[8*g +: 8] = regs_q[g];
  end

  assign txdata    = txdata_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;
  localparam int NREGS = 8;
`ifdef SPI_REG_BANK_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               resetn;
  logic               ss;
  logic [7:0]         rxdata;
  logic               rxready;
  logic               txready;
  logic [7:0]         txdata;
  logic [7:0]         ro_data;
  logic [8*NREGS-1:0] regs_out;
  logic               wr_strobe;
  logic [6:0]         wr_addr;

  spi_reg_bank #(.NREGS(NREGS)) dut (
    .clk(clk), .resetn(resetn), .ss(ss), .rxdata(rxdata), .rxready(rxready),
    .txready(txready), .txdata(txdata), .ro_data(ro_data), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Frame-level reference: each data byte's address follows from its index
  // in the frame and the start address.
  logic [7:0] mreg [NREGS];
  int         m_idx;
  logic [7:0] m_cmd;
  logic [7:0] m_tx;
  logic       m_st;
  logic [6:0] m_wa;

  function automatic logic [7:0] m_rd(input int a, input logic [7:0] ro);
    if (a < NREGS) return mreg[a];
    if (a == 127) return ro;
    return 8'h00;
  endfunction

  function automatic logic [63:0] m_regs();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++) r[8*i +: 8] = mreg[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mreg[i] = 8'h00;
    m_idx = 0; m_cmd = 8'h00; m_tx = 8'hA5; m_st = 1'b0; m_wa = 7'd0;
  endtask

  task automatic model_desel();
    m_idx = 0;
    m_tx  = 8'hA5;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [7:0] ro);
    int off;
    int a;
    m_st = 1'b0;
    if (m_idx == 0) begin
      m_cmd = b;
      if (!b[7]) m_tx = m_rd(int'(b[6:0]), ro);
    end else begin
      off = AUTO ? (m_cmd[7] ? m_idx - 1 : m_idx) : 0;
      a   = (int'(m_cmd[6:0]) + off) % 128;
      if (m_cmd[7]) begin
        if (a < NREGS) begin
          mreg[a] = b;
          m_st    = 1'b1;
          m_wa    = 7'(a);
        end
      end else begin
        m_tx = m_rd(a, ro);
      end
    end
    m_idx++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] ro);
    rxdata  = b;
    ro_data = ro;
    rxready = 1'b1;
    step();
    rxready = 1'b0;
    model_byte(b, ro);
  endtask

  task automatic do_select();
    ss = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_deselect();
    ss = 1'b1;
    repeat (3) step();
    model_desel();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".txdata"}, 64'(txdata), 64'(m_tx));
    chk({tag, ".wr_strobe"}, 64'(wr_strobe), 64'(m_st));
    chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_wa));
    chk({tag, ".regs"}, regs_out, m_regs());
  endtask

  typedef struct {
    logic [7:0] b;
    logic [7:0] ro;
    logic [7:0] tx;
    logic       st;
    logic [6:0] wa;
    bit         desel;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] b, input logic [7:0] ro, input logic [7:0] tx,
                     input logic st, input logic [6:0] wa, input bit desel);
    vec_t v;
    v = '{b: b, ro: ro, tx: tx, st: st, wa: wa, desel: desel};
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] wl;
    resetn = 1'b0; ss = 1'b1; rxdata = 8'h00; rxready = 1'b0;
    txready = 1'b0; ro_data = 8'h00;
    model_reset();
    #22;
    resetn = 1'b1;
    step();

    do_select();
    chk("reset.txdata", 64'(txdata), 64'hA5);
    chk("reset.regs", regs_out, 64'h0);
    chk("reset.wr_strobe", 64'(wr_strobe), 64'h0);
    chk("reset.wr_addr", 64'(wr_addr), 64'h0);

    // Directed frames from the test plan, applied as one byte stream.
    wl = AUTO ? 7'd2 : 7'd0;
    add(8'h82, 8'h00, 8'hA5, 1'b0, 7'd0, 1'b0);
    add(8'h3C, 8'h00, 8'hA5, 1'b1, 7'd2, 1'b1);
    add(8'h80, 8'h00, 8'hA5, 1'b0, 7'd2, 1'b0);
    add(8'h11, 8'h00, 8'hA5, 1'b1, 7'd0, 1'b0);
    add(8'h22, 8'h00, 8'hA5, 1'b1, AUTO ? 7'd1 : 7'd0, 1'b0);
    add(8'h33, 8'h00, 8'hA5, 1'b1, wl, 1'b1);
    add(8'h00, 8'h00, AUTO ? 8'h11 : 8'h33, 1'b0, wl, 1'b0);
    add(8'hFF, 8'h00, AUTO ? 8'h22 : 8'h33, 1'b0, wl, 1'b0);
    add(8'hFF, 8'h00, 8'h33, 1'b0, wl, 1'b0);
    add(8'hFF, 8'h00, AUTO ? 8'h00 : 8'h33, 1'b0, wl, 1'b1);
    add(8'h7F, 8'h05, 8'h05, 1'b0, wl, 1'b0);
    add(8'hFF, 8'h5A, AUTO ? 8'h11 : 8'h5A, 1'b0, wl, 1'b1);
    add(8'h8A, 8'h00, 8'hA5, 1'b0, wl, 1'b0);
    add(8'hFF, 8'h00, 8'hA5, 1'b0, wl, 1'b1);
    add(8'h84, 8'h00, 8'hA5, 1'b0, wl, 1'b1);
    add(8'h05, 8'h00, 8'h00, 1'b0, wl, 1'b0);
    add(8'hFF, 8'h00, 8'h00, 1'b0, wl, 1'b1);

    foreach (tbl[i]) begin
      send(tbl[i].b, tbl[i].ro);
      chk($sformatf("vec%0d.txdata", i), 64'(txdata), 64'(tbl[i].tx));
      chk($sformatf("vec%0d.wr_strobe", i), 64'(wr_strobe), 64'(tbl[i].st));
      chk($sformatf("vec%0d.wr_addr", i), 64'(wr_addr), 64'(tbl[i].wa));
      chk($sformatf("vec%0d.regs", i), regs_out, m_regs());
      step();
      chk($sformatf("vec%0d.strobe_off", i), 64'(wr_strobe), 64'h0);
      if (tbl[i].desel) begin
        do_deselect();
        chk($sformatf("vec%0d.desel_tx", i), 64'(txdata), 64'hA5);
        do_select();
      end
    end
    chk("table.final_regs", regs_out, AUTO ? 64'h0000_0000_0033_2211 : 64'h0000_0000_003C_0033);

    // Byte arriving in the same cycle that deselect takes effect.
    send(8'h83, 8'h00);
    ss = 1'b1;
    step();
    step();
    send(8'h77, 8'h00);
    model_desel();
    chk("desel_same.strobe", 64'(wr_strobe), 64'h1);
    chk("desel_same.wr_addr", 64'(wr_addr), 64'h3);
    chk("desel_same.txdata", 64'(txdata), 64'hA5);
    chk("desel_same.regs", regs_out, m_regs());
    step();
    do_select();
    send(8'h03, 8'h00);
    chk("desel_same.readback", 64'(txdata), 64'h77);

    // txready must leave txdata alone.
    txready = 1'b1;
    step();
    txready = 1'b0;
    chk("txready.hold", 64'(txdata), 64'h77);
    do_deselect();
    do_select();

    // Reset in the middle of a write frame.
    send(8'h81, 8'h00);
    send(8'h99, 8'h00);
    chk("midreset.pre_regs", regs_out, m_regs());
    resetn = 1'b0;
    #2;
    chk("midreset.regs", regs_out, 64'h0);
    chk("midreset.txdata", 64'(txdata), 64'hA5);
    chk("midreset.wr_addr", 64'(wr_addr), 64'h0);
    resetn = 1'b1;
    model_reset();
    step();
    do_select();
    send(8'h01, 8'h00);
    chk("midreset.read", 64'(txdata), 64'h00);
    do_deselect();
    do_select();

    // Random frames against the reference.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] cmd;
      int len;
      cmd[7]   = 1'($urandom_range(0, 1));
      cmd[6:0] = ($urandom_range(0, 3) == 0) ? 7'(127 - $urandom_range(0, 1))
                                             : 7'($urandom_range(0, NREGS + 2));
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        send((k == 0) ? cmd : 8'($urandom), 8'($urandom));
        chk_model($sformatf("rnd%0d.%0d", f, k));
        txready = 1'($urandom_range(0, 1));
        step();
        txready = 1'b0;
        chk($sformatf("rnd%0d.%0d.strobe_off", f, k), 64'(wr_strobe), 64'h0);
        repeat ($urandom_range(0, 2)) step();
        chk($sformatf("rnd%0d.%0d.tx_hold", f, k), 64'(txdata), 64'(m_tx));
      end
      do_deselect();
      chk($sformatf("rnd%0d.desel_tx", f), 64'(txdata), 64'hA5);
      do_select();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
